// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the byte-wide RAM arbiter.
// Length codes, FSM states, owner ids and byte-lane helpers.
package mem_arbiter_pkg;

    localparam int RAM_ADDR_W_DEF = 17;

    localparam logic [1:0] MEM_LEN_B = 2'd0;
    localparam logic [1:0] MEM_LEN_H = 2'd1;
    localparam logic [1:0] MEM_LEN_W = 2'd2;

    typedef enum logic [1:0] {
        MEMARB_IDLE,
        MEMARB_XFER,
        MEMARB_DONE
    } arb_state_t;

    typedef enum logic {
        OWNER_IF,
        OWNER_MEM
    } owner_t;

    // Index of the final byte for a length code; code 3 behaves as a word.
    function automatic logic [1:0] len_last(input logic [1:0] len);
        logic [1:0] last;
        case (len)
            MEM_LEN_B: last = 2'd0;
            MEM_LEN_H: last = 2'd1;
            default:   last = 2'd3;
        endcase
        return last;
    endfunction

    function automatic logic [31:0] put_byte(
        input logic [31:0] word,
        input logic [1:0]  idx,
        input logic [7:0]  b
    );
        return word | (32'(b) << {idx, 3'b000});
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle between the IF/MEM stages and the RAM arbiter.
// master = pipeline stages, slave = arbiter.
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;

    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;

    logic        rqif_staller;
    logic        rqmem_staller;

    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        input  if_done, if_inst, mem_done, mem_rdata,
        input  rqif_staller, rqmem_staller
    );

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        output if_done, if_inst, mem_done, mem_rdata,
        output rqif_staller, rqmem_staller
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide synchronous RAM port between IF and MEM,
// sequencing 1/2/4 byte accesses and assembling little-endian words.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_ADDR_W = RAM_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_arbiter_if.slave          bus,
    output logic [RAM_ADDR_W-1:0] o_ram_addr,
    output logic                  o_ram_we,
    output logic [7:0]            o_ram_dout,
    input  logic [7:0]            i_ram_din
);

    arb_state_t            r_state;
    owner_t                r_owner;
    logic                  r_we;
    logic [1:0]            r_last;
    logic [1:0]            r_cnt;
    logic [RAM_ADDR_W-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_buf;

    logic [RAM_ADDR_W-1:0] r_ram_addr;
    logic                  r_ram_we;
    logic [7:0]            r_ram_dout;
    logic                  r_if_done;
    logic                  r_mem_done;
    logic [31:0]           r_if_inst;
    logic [31:0]           r_mem_rdata;

    logic                  w_mem_sel;
    logic                  w_req_we;
    logic [1:0]            w_req_last;
    logic [RAM_ADDR_W-1:0] w_req_addr;
    logic [31:0]           w_req_wdata;
    logic [1:0]            w_next_cnt;
    logic [7:0]            w_wbyte;
    logic [31:0]           w_merged;
    logic                  w_unused;

    // MEM wins whenever both stages ask in the same cycle.
    assign w_mem_sel   = bus.mem_req;
    assign w_req_we    = w_mem_sel & bus.mem_we;
    assign w_req_last  = w_mem_sel ? len_last(bus.mem_len) : 2'd3;
    assign w_req_addr  = w_mem_sel ? bus.mem_addr[RAM_ADDR_W-1:0]
                                   : bus.if_addr[RAM_ADDR_W-1:0];
    assign w_req_wdata = w_mem_sel ? bus.mem_wdata : 32'd0;

    assign w_next_cnt = r_cnt + 2'd1;
    assign w_wbyte    = r_wdata[{w_next_cnt, 3'b000} +: 8];
    assign w_merged   = put_byte(r_buf, r_cnt, i_ram_din);

    // Upper address bits are beyond the RAM and intentionally dropped.
    assign w_unused = ^{bus.if_addr, bus.mem_addr};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= MEMARB_IDLE;
            r_owner     <= OWNER_IF;
            r_we        <= 1'b0;
            r_last      <= 2'd0;
            r_cnt       <= 2'd0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_buf       <= 32'd0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_dout  <= 8'd0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_inst   <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            unique case (r_state)
                MEMARB_IDLE: begin
                    if (bus.mem_req || bus.if_req) begin
                        r_owner    <= w_mem_sel ? OWNER_MEM : OWNER_IF;
                        r_we       <= w_req_we;
                        r_last     <= w_req_last;
                        r_cnt      <= 2'd0;
                        r_addr     <= w_req_addr;
                        r_wdata    <= w_req_wdata;
                        r_buf      <= 32'd0;
                        r_ram_addr <= w_req_addr;
                        r_ram_we   <= w_req_we;
                        r_ram_dout <= w_req_wdata[7:0];
                        r_state    <= MEMARB_XFER;
                    end
                end
                MEMARB_XFER: begin
                    if (r_cnt == r_last) begin
                        r_ram_we <= 1'b0;
                        r_state  <= MEMARB_DONE;
                        if (r_owner == OWNER_MEM) begin
                            r_mem_done <= 1'b1;
                            if (!r_we) r_mem_rdata <= w_merged;
                        end else begin
                            r_if_done <= 1'b1;
                            r_if_inst <= w_merged;
                        end
                    end else begin
                        r_cnt      <= w_next_cnt;
                        r_buf      <= w_merged;
                        r_ram_addr <= r_addr + RAM_ADDR_W'(w_next_cnt);
                        r_ram_dout <= w_wbyte;
                    end
                end
                MEMARB_DONE: begin
                    // Requests are not sampled here so a held one is not re-taken.
                    r_state <= MEMARB_IDLE;
                end
                default: r_state <= MEMARB_IDLE;
            endcase
        end
    end

    assign o_ram_addr = r_ram_addr;
    assign o_ram_we   = r_ram_we;
    assign o_ram_dout = r_ram_dout;

    assign bus.if_done   = r_if_done;
    assign bus.if_inst   = r_if_inst;
    assign bus.mem_done  = r_mem_done;
    assign bus.mem_rdata = r_mem_rdata;

    assign bus.rqif_staller  = bus.if_req & ~r_if_done;
    assign bus.rqmem_staller = bus.mem_req & ~r_mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural async-read byte RAM.
// Expected values are hand-computed per vector.
module tb_mem_arbiter;

    localparam int AW = 17;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din;

    logic [7:0]    ram [0:(1<<AW)-1];
    logic          pk_en;
    logic [AW-1:0] pk_a;
    logic [7:0]    pk_d;

    int n_tot;
    int n_bad;

    mem_arbiter_if bus();

    mem_arbiter #(.RAM_ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_ram_addr (ram_addr),
        .o_ram_we   (ram_we),
        .o_ram_dout (ram_dout),
        .i_ram_din  (ram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_din = ram[ram_addr];

    always @(posedge clk) begin
        if (pk_en) ram[pk_a] <= pk_d;
        else if (ram_we) ram[ram_addr] <= ram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
        pk_en = 1'b1;
        pk_a  = a;
        pk_d  = d;
        tick();
        pk_en = 1'b0;
    endtask

    task automatic run_req(
        input  bit          is_mem,
        input  bit          we,
        input  logic [1:0]  len,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        output int          dcyc,
        output int          wcnt,
        output int          odone,
        output int          xcnt,
        output int          st0
    );
        if (is_mem) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we;
            bus.mem_len   = len;
            bus.mem_addr  = addr;
            bus.mem_wdata = wd;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end
        #1;
        st0   = is_mem ? int'(bus.rqmem_staller) : int'(bus.rqif_staller);
        dcyc  = -1;
        wcnt  = 0;
        odone = 0;
        xcnt  = 0;
        for (int k = 1; k <= 20 && dcyc < 0; k++) begin
            tick();
            if (ram_we) wcnt++;
            if ($isunknown(ram_addr)) xcnt++;
            if (is_mem ? bus.if_done : bus.mem_done) odone++;
            if (is_mem ? bus.mem_done : bus.if_done) begin
                dcyc = k;
                bus.mem_req = 1'b0;
                bus.if_req  = 1'b0;
            end
        end
        bus.mem_req = 1'b0;
        bus.if_req  = 1'b0;
        tick();
    endtask

    initial begin
        int dc, wc, od, xc, s0;
        int md, ia, id, stl, cnt, dbl;
        logic prev;

        n_tot = 0;
        n_bad = 0;
        pk_en = 1'b0;
        pk_a  = '0;
        pk_d  = 8'd0;
        rst   = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'd0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_len   = 2'd0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;

        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_dout", 32'(ram_dout), 32'd0);
        chk("rst_ifdone", 32'(bus.if_done), 32'd0);
        chk("rst_memdone", 32'(bus.mem_done), 32'd0);
        chk("rst_inst", bus.if_inst, 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_stall", 32'({bus.rqif_staller, bus.rqmem_staller}), 32'd0);

        poke(17'h10, 8'h13);
        poke(17'h11, 8'h02);
        poke(17'h12, 8'h50);
        poke(17'h13, 8'h00);
        poke(17'h200, 8'h80);
        poke(17'h1FFFF, 8'h34);
        poke(17'h0, 8'h12);
        poke(17'h300, 8'h11);
        poke(17'h301, 8'h11);
        poke(17'h302, 8'h11);
        poke(17'h303, 8'h11);

        // IF word fetch
        run_req(1'b0, 1'b0, 2'd2, 32'h10, 32'd0, dc, wc, od, xc, s0);
        chk("if_inst", bus.if_inst, 32'h00500213);
        chk("if_cyc", 32'(dc), 32'd5);
        chk("if_we", 32'(wc), 32'd0);
        chk("if_other", 32'(od), 32'd0);
        chk("if_stall0", 32'(s0), 32'd1);
        chk("if_stall_end", 32'(bus.rqif_staller), 32'd0);

        // MEM store word
        run_req(1'b1, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, dc, wc, od, xc, s0);
        chk("sw_cyc", 32'(dc), 32'd5);
        chk("sw_wcnt", 32'(wc), 32'd4);
        chk("sw_ram", {ram[17'h103], ram[17'h102], ram[17'h101], ram[17'h100]},
            32'hDEADBEEF);
        chk("sw_stall0", 32'(s0), 32'd1);

        // len code 3 reads a full word
        run_req(1'b1, 1'b0, 2'd3, 32'h100, 32'd0, dc, wc, od, xc, s0);
        chk("lw3_data", bus.mem_rdata, 32'hDEADBEEF);
        chk("lw3_cyc", 32'(dc), 32'd5);

        // Simultaneous IF fetch and MEM lb: MEM first
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h10;
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_len  = 2'd0;
        bus.mem_addr = 32'h200;
        md  = -1;
        ia  = -1;
        id  = -1;
        stl = 0;
        for (int k = 1; k <= 20 && id < 0; k++) begin
            tick();
            if (bus.mem_done && md < 0) begin
                md = k;
                bus.mem_req = 1'b0;
            end
            if (ia < 0 && md > 0 && ram_addr == 17'h10) ia = k;
            if (bus.if_done) begin
                id = k;
                bus.if_req = 1'b0;
            end else if (!bus.rqif_staller) begin
                stl++;
            end
        end
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        tick();
        chk("arb_memcyc", 32'(md), 32'd2);
        chk("arb_rdata", bus.mem_rdata, 32'h00000080);
        chk("arb_ifacc", 32'(ia), 32'd4);
        chk("arb_ifcyc", 32'(id), 32'd8);
        chk("arb_stall", 32'(stl), 32'd0);
        chk("arb_inst", bus.if_inst, 32'h00500213);

        // Halfword wrapping past the RAM top
        run_req(1'b1, 1'b0, 2'd1, 32'h1FFFF, 32'd0, dc, wc, od, xc, s0);
        chk("wrap_data", bus.mem_rdata, 32'h00001234);
        chk("wrap_cyc", 32'(dc), 32'd3);
        chk("wrap_x", 32'(xc), 32'd0);

        // Held request: one pulse per 3-cycle byte access
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_len  = 2'd0;
        bus.mem_addr = 32'h200;
        cnt  = 0;
        dbl  = 0;
        prev = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (bus.mem_done) cnt++;
            if (bus.mem_done && prev) dbl++;
            prev = bus.mem_done;
        end
        bus.mem_req = 1'b0;
        tick();
        chk("held_cnt", 32'(cnt), 32'd3);
        chk("held_dbl", 32'(dbl), 32'd0);

        // Reset in the middle of a store
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_len   = 2'd2;
        bus.mem_addr  = 32'h300;
        bus.mem_wdata = 32'hA1B2C3D4;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_we", 32'(ram_we), 32'd0);
        chk("mid_done", 32'(bus.mem_done), 32'd0);
        chk("mid_addr", 32'(ram_addr), 32'd0);
        chk("mid_rdata", bus.mem_rdata, 32'd0);
        chk("mid_inst", bus.if_inst, 32'd0);
        rst = 1'b0;
        bus.mem_req = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (bus.mem_done || ram_we) cnt++;
        end
        chk("mid_quiet", 32'(cnt), 32'd0);
        chk("mid_ram", {ram[17'h303], ram[17'h302], ram[17'h301], ram[17'h300]},
            32'h1111C3D4);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
